// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// decoder control bundle, MIPS opcodes and the branch offset helper.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TO_W  = 8;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_EXEC  = 2'd2
  } fetch_state_e;

  // Decoder control lines that steer the next-PC mux.
  typedef struct packed {
    logic branch;
    logic jump;
    logic jump_reg;
    logic inv_zero;
    logic zero;
  } npc_ctrl_t;

  // Opcodes and function codes shared with the decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Sign-extended 16-bit immediate shifted to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// next_pc_logic: combinational next-PC target computation and priority mux.
// Ports:
//   pc_plus4        in  32  sequential address of the current instruction
//   instr_index     in  26  instruction[25:0] (jump index / branch immediate)
//   ctrl            in      decoder control bundle (branch/jump/jr/inv_zero/zero)
//   da              in  32  register-file read A, jr target
//   next_pc_c       out 32  selected next PC
//   jr_misaligned_c out 1   jr selected with a non word-aligned target
module next_pc_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  npc_ctrl_t   ctrl,
  input  logic [31:0] da,
  output logic [31:0] next_pc_c,
  output logic        jr_misaligned_c
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;

  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(instr_index[15:0]);
  assign branch_taken  = ctrl.branch & (ctrl.zero ^ ctrl.inv_zero);

  // Priority: jr > j/jal > taken branch > sequential.
  always_comb begin
    next_pc_c       = pc_plus4;
    jr_misaligned_c = 1'b0;
    if (ctrl.jump_reg) begin
      next_pc_c       = {da[31:2], 2'b00};
      jr_misaligned_c = |da[1:0];
    end else if (ctrl.jump) begin
      next_pc_c = jump_target;
    end else if (branch_taken) begin
      next_pc_c = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the PC, fetches one word per instruction over a
// req/valid handshake, presents it to the decoder for one execute cycle (longer
// under stall), then advances the PC from the decoder's control lines.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and word address (= pc)
//   imem_rdata/valid    memory response, only honoured in FETCH
//   stall               freezes EXEC
//   Branch/Jump/JumpReg/InvZero/Zero/Da  next-PC controls, sampled on EXEC exit
//   instruction/instr_valid  current instruction to the decoder
//   pc/pc_plus4         current address and its link value
//   fetch_err           sticky fetch timeout / misaligned jr flag
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        InvZero,
  input  logic        Zero,
  input  logic [31:0] Da,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d;
  logic            ivalid_q, ivalid_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  npc_ctrl_t   ctrl;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign ctrl = '{branch: Branch, jump: Jump, jump_reg: JumpReg,
                  inv_zero: InvZero, zero: Zero};

  next_pc_logic u_next_pc (
    .pc_plus4        (pc_plus4),
    .instr_index     (instr_q[25:0]),
    .ctrl            (ctrl),
    .da              (Da),
    .next_pc_c       (next_pc),
    .jr_misaligned_c (jr_misaligned)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      ivalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_FETCH;
        cnt_d   = '0;
      end
      FETCH_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = FETCH_EXEC;
        end else if (cnt_q == TO_W'(IMEM_TIMEOUT)) begin
          // Keep waiting after the timeout; only flag it.
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      FETCH_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH_FETCH;
          cnt_d   = '0;
          if (jr_misaligned) err_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    // Handshake outputs registered from the upcoming state.
    req_d    = (state_d == FETCH_FETCH);
    ivalid_d = (state_d == FETCH_EXEC);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = ivalid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized instruction streams checked against a behavioural PC model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        Branch, Jump, JumpReg, InvZero, Zero;
  logic [31:0] Da;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pc;
  logic        m_err;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall),
    .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
    .InvZero(InvZero), .Zero(Zero), .Da(Da),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Next PC from the ISA rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] instr,
                                             input bit br, input bit j, input bit jr,
                                             input bit inv, input bit z, input logic [31:0] da);
    logic [31:0] p4;
    logic [15:0] imm;
    int          off;
    p4  = cur_pc + 32'd4;
    imm = instr[15:0];
    off = int'($signed(imm));
    if (jr) return da - (da % 32'd4);
    if (j) return (p4 & 32'hF000_0000) + ((instr % 32'h0400_0000) * 32'd4);
    if (br && (z != inv)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic drive_ctrl_random();
    Branch  = 1'($urandom_range(0, 1));
    Jump    = 1'($urandom_range(0, 1));
    JumpReg = 1'($urandom_range(0, 1));
    InvZero = 1'($urandom_range(0, 1));
    Zero    = 1'($urandom_range(0, 1));
    Da      = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_valid = 1'b0; stall = 1'b0;
    drive_ctrl_random();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_ivalid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_err", 32'(fetch_err), 32'd0);
    reset = 1'b0;
    m_pc  = RST_PC;
    m_err = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req) check("req_wait", 32'(imem_req), 32'd1);
  endtask

  // One full instruction: fetch with latency, hold under stall, then retire.
  task automatic exec_one(input logic [31:0] rdata, input int lat, input int stalls,
                          input bit br, input bit j, input bit jr,
                          input bit inv, input bit z, input logic [31:0] da);
    wait_req();
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_ivalid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("req_hold", 32'(imem_req), 32'd1);
    end
    imem_valid = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_valid = 1'b0;
    check("exec_ivalid", 32'(instr_valid), 32'd1);
    check("exec_instr", instruction, rdata);
    check("exec_pc", pc, m_pc);
    check("exec_pc4", pc_plus4, m_pc + 32'd4);
    check("exec_req", 32'(imem_req), 32'd0);
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      drive_ctrl_random();
      @(negedge clk);
      check("stall_instr", instruction, rdata);
      check("stall_pc", pc, m_pc);
      check("stall_ivalid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0; imem_valid = 1'b0;
    Branch = br; Jump = j; JumpReg = jr; InvZero = inv; Zero = z; Da = da;
    @(negedge clk);
    if (jr && (da % 32'd4) != 0) m_err = 1'b1;
    m_pc = model_next(m_pc, rdata, br, j, jr, inv, z, da);
    drive_ctrl_random();
    check("retire_err", 32'(fetch_err), 32'(m_err));
    check("retire_ivalid", 32'(instr_valid), 32'd0);
    check("retire_pc", pc, m_pc);
  endtask

  task automatic jr_to(input logic [31:0] target);
    exec_one($urandom, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, target);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
    Branch = 0; Jump = 0; JumpReg = 0; InvZero = 0; Zero = 0; Da = '0;

    // Directed scenarios.
    do_reset();
    exec_one(32'h2047_000F, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("seq_after_reset", m_pc, 32'h0000_0004);
    jr_to(32'h0000_0010);
    exec_one(32'h1000_FFFC, 0, 0, 1, 0, 0, 0, 1, 32'h0);  // beq taken
    check("beq_taken", pc, 32'h0000_0004);
    jr_to(32'h0000_0010);
    exec_one(32'h1000_FFFC, 1, 0, 1, 0, 0, 0, 0, 32'h0);  // beq not taken
    check("beq_not_taken", pc, 32'h0000_0014);
    jr_to(32'h0000_0010);
    exec_one(32'h1400_FFFC, 2, 0, 1, 0, 0, 1, 0, 32'h0);  // bne taken
    check("bne_taken", pc, 32'h0000_0004);
    jr_to(32'h8000_0000);
    exec_one(32'h0C00_0100, 0, 3, 0, 1, 0, 0, 0, 32'h0);  // jal with 3 stalls
    check("jal_target", pc, 32'h8000_0400);
    jr_to(32'hFFFF_FFFC);
    exec_one(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0);  // sequential wrap
    check("seq_wrap", pc, 32'h0000_0000);
    exec_one(32'h0000_0008, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0123);  // jr wins
    check("jr_priority", pc, 32'h0000_0120);
    check("jr_misalign_err", 32'(fetch_err), 32'd1);

    // Randomized stream with aligned jr targets.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] rd;
      bit br, j, jr;
      rd = $urandom;
      jr = ($urandom_range(0, 5) == 0);
      j  = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 1) == 0);
      exec_one(rd, $urandom_range(0, 3), $urandom_range(0, 2), br, j, jr,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC);
    end

    // Fetch timeout: flag after the limit, keep waiting, then complete.
    do_reset();
    wait_req();
    imem_valid = 1'b0;
    repeat (240) @(negedge clk);
    check("to_early_err", 32'(fetch_err), 32'd0);
    repeat (60) @(negedge clk);
    check("to_late_err", 32'(fetch_err), 32'd1);
    check("to_req_held", 32'(imem_req), 32'd1);
    m_err = 1'b1;
    exec_one(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Reset mid-fetch with a late response arriving around reset.
    wait_req();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem_valid = 1'b0;
    check("midrst_pc", pc, RST_PC);
    check("midrst_err", 32'(fetch_err), 32'd0);
    check("midrst_req_again", 32'(imem_req), 32'd1);
    check("midrst_ivalid", 32'(instr_valid), 32'd0);
    check("midrst_instr", instruction, 32'd0);
    m_pc = RST_PC; m_err = 1'b0;
    exec_one(32'h0000_0042, 1, 0, 0, 0, 0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream neighbour of the instruction decoder in the MP3 CPU. Holds the PC and fetches a 32-bit word from instruction memory through a req/valid handshake. Presents the instruction to the decoder for exactly one execute cycle, then computes the next PC. Next-PC sources are sequential, branch (beq/bne via Zero/InvZero), jump (j/jal) and jump-register (jr), driven by the decoder's Branch, Jump, JumpReg and InvZero lines.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_TIMEOUT, 255, max cycles to wait for imem_valid before flagging fetch_err (8-bit counter)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request, held high until imem_valid
imem_addr  out  32  word-aligned fetch address (= pc)
imem_rdata  in  32  instruction word, sampled when imem_valid=1 in FETCH
imem_valid  in  1  memory response strobe
stall  in  1  freeze in EXEC; no PC update, instruction held
Branch  in  1  from decoder
Jump  in  1  from decoder
JumpReg  in  1  from decoder
InvZero  in  1  from decoder; 1 = bne
Zero  in  1  ALU zero flag for the current instruction
Da  in  32  register-file read A (jr target)
instruction  out  32  current instruction to decoder
instr_valid  out  1  high in EXEC; datapath commits only when instr_valid & ~stall
pc  out  32  address of current instruction
pc_plus4  out  32  pc+4, link value for jal
fetch_err  out  1  sticky: timeout expired or misaligned jr target

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0.
- States: IDLE -> FETCH (unconditional, next cycle). FETCH: imem_req=1, imem_addr=pc; imem_valid=1 -> latch imem_rdata into instruction, go EXEC; else count++. EXEC: instr_valid=1; stall=1 -> stay; stall=0 -> load next_pc, go FETCH.
- Minimum latency per instruction: 2 cycles (FETCH with same-cycle valid, then EXEC).
- imem_valid outside FETCH is ignored. Reset mid-fetch drops imem_req; a late response is discarded.
- Timeout: counter reaches IMEM_TIMEOUT in FETCH -> set fetch_err, keep waiting (no abort). Counter clears on entering FETCH.
- next_pc priority: JumpReg > Jump > taken branch > sequential.
  - jr: {Da[31:2],2'b00}; Da[1:0]!=0 sets fetch_err.
  - j/jal: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - branch taken = Branch & (Zero ^ InvZero); target = pc_plus4 + (sign-extended instruction[15:0] << 2).
  - otherwise pc_plus4.
- All adds are 32-bit modulo (wrap at 2^32, no flag).
- pc_plus4 is combinational from pc, valid in all states.
- Decoder inputs are sampled only in the EXEC cycle with stall=0.

Decomposition:
- Shared package/header: FETCH_IDLE/FETCH_FETCH/FETCH_EXEC state encodings (2-bit), RESET_PC default, opcode defines already used by the decoder.
- One sub-module: next_pc_logic (combinational target computation and priority mux), unit-tested separately.

Test Plan:
- Reset then imem_valid same cycle, rdata=32'h2047000F -> imem_addr=0, instr_valid in cycle 2, next fetch addr=0x4.
- pc=0x10, beq, Zero=1, imm=16'hFFFC -> next pc=0x14-0x10=0x04; same with Zero=0 -> 0x14; bne (InvZero=1), Zero=0 -> 0x04.
- pc=0x8000_0000, jal target field 26'h0000100 -> next pc=0x8000_0400, pc_plus4=0x8000_0004 during EXEC.
- jr with Da=0x0000_0123 and Jump=1 also asserted -> next pc=0x0000_0120 (JumpReg wins), fetch_err=1.
- stall held 3 EXEC cycles -> instruction and pc unchanged, imem_req=0; stall release -> single PC update.
- imem_valid withheld 300 cycles -> fetch_err=1 after 255; reset asserted mid-FETCH with late valid -> pc=RESET_PC, response ignored, fetch_err=0.
